// File: rtl/picorv_irq_ctrl.sv
// Purpose : fixed-priority interrupt controller with latched/level channels, mask register and optional one-shot timer on channel 0.
// Latency : irq_req rises one cycle after a pending bit sets; irq_id is frozen while irq_req is high; one idle GAP cycle follows each acceptance.
// Backpressure: a request holds until irq_ack; irq_ack with irq_req low is ignored; new events keep accumulating in pending meanwhile.
//
// Ports:
//   clk, resetn              - single clock domain, async active-low reset
//   irq_in[NUM_IRQ]          - raw interrupt lines
//   mask_wr, mask_wdata      - mask register write (permanently masked channels stay 1)
//   timer_wr, timer_wdata    - timer load (only with PICORV_IRQ_TIMER_EN)
//   irq_req, irq_id, irq_ack - request/grant handshake towards the CPU
//   irq_pending, irq_mask    - state visibility
//   timer_q                  - current timer value (0 when timer is not built)
//
// Build option: define PICORV_IRQ_TIMER_EN to include the countdown timer that
// raises a latched event on channel 0 when it reaches zero.

module picorv_irq_ctrl #(
    parameter int          NUM_IRQ     = 32,
    parameter logic [31:0] MASKED_IRQ  = 32'h0000_0000,
    parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
    parameter int          TIMER_W     = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               timer_wr,
    input  logic [TIMER_W-1:0] timer_wdata,
    output logic               irq_req,
    output logic [4:0]         irq_id,
    input  logic               irq_ack,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [NUM_IRQ-1:0] irq_mask,
    output logic [TIMER_W-1:0] timer_q
);

    localparam logic [NUM_IRQ-1:0] P_MASKED  = MASKED_IRQ[NUM_IRQ-1:0];
    localparam logic [NUM_IRQ-1:0] P_LATCHED = LATCHED_IRQ[NUM_IRQ-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_id;
    logic [4:0]         w_id_nxt;
    logic [4:0]         w_win;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_active;
    logic [NUM_IRQ-1:0] w_clr;
    logic               w_accept;
    logic               w_tpend;

    // Acceptance only counts while a request is actually being presented.
    assign w_accept = irq_ack && (r_state == S_REQ);

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_accept && (r_id == i[4:0]);
        end
    end

    // A new sample on a latched line wins over a same-edge acceptance clear.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (P_MASKED[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (P_LATCHED[i]) begin
                w_pend_nxt[i] = irq_in[i] | (r_pend[i] & ~w_clr[i]);
            end else begin
                w_pend_nxt[i] = irq_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= '0;
            r_mask <= '1;
        end else begin
            r_pend <= w_pend_nxt;
            if (mask_wr) begin
                r_mask <= mask_wdata | P_MASKED;
            end
        end
    end

`ifdef PICORV_IRQ_TIMER_EN
    logic [TIMER_W-1:0] r_timer;
    logic               r_tpend;
    logic               w_tevt;

    // Expiry is the 1->0 step; a load on that same edge suppresses it.
    assign w_tevt = !timer_wr && (r_timer == TIMER_W'(1)) && !P_MASKED[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
            r_tpend <= 1'b0;
        end else begin
            if (timer_wr) begin
                r_timer <= timer_wdata;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - TIMER_W'(1);
            end
            // Timer event is always sticky, even when channel 0 is level.
            r_tpend <= w_tevt | (r_tpend & ~w_clr[0]);
        end
    end

    assign timer_q = r_timer;
    assign w_tpend = r_tpend;
`else
    logic w_unused_timer;
    assign w_unused_timer = ^{timer_wr, timer_wdata};
    assign timer_q        = '0;
    assign w_tpend        = 1'b0;
`endif

    always_comb begin
        irq_pending    = r_pend;
        irq_pending[0] = r_pend[0] | w_tpend;
    end

    assign irq_mask = r_mask;
    assign w_active = irq_pending & ~r_mask;

    // Lowest active index wins; scan downward so the last hit is the lowest.
    always_comb begin
        w_win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win = i[4:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // The id is captured on IDLE->REQ and not touched again until the GAP.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        irq_req     = 1'b0;
        irq_id      = '0;
        case (r_state)
            S_IDLE: begin
                if (|w_active) begin
                    w_state_nxt = S_REQ;
                    w_id_nxt    = w_win;
                end
            end
            S_REQ: begin
                irq_req = 1'b1;
                irq_id  = r_id;
                if (irq_ack) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_picorv_irq_ctrl.sv
// Bench for picorv_irq_ctrl: channel 2 permanently masked, channel 7 level,
// all others latched, 16-bit timer. A cycle model is compared every cycle,
// and directed scenarios pin it with literal expectations.
module tb_picorv_irq_ctrl;

    localparam logic [31:0] MSK = 32'h0000_0004;
    localparam logic [31:0] LAT = 32'hffff_ff7f;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] irq_in = '0;
    logic        mask_wr = 1'b0;
    logic [31:0] mask_wdata = '0;
    logic        timer_wr = 1'b0;
    logic [15:0] timer_wdata = '0;
    logic        irq_ack = 1'b0;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic [31:0] irq_pending;
    logic [31:0] irq_mask;
    logic [15:0] timer_q;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    picorv_irq_ctrl #(
        .NUM_IRQ    (32),
        .MASKED_IRQ (MSK),
        .LATCHED_IRQ(LAT),
        .TIMER_W    (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .timer_wr   (timer_wr),
        .timer_wdata(timer_wdata),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_pending(irq_pending),
        .irq_mask   (irq_mask),
        .timer_q    (timer_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = no request shown, 1 = request shown, 2 = one quiet cycle after acceptance
    logic [31:0] m_pend, m_mask, nx_pend, act, low;
    logic        m_tpend, acc, tevt;
    int          m_phase;
    logic [4:0]  m_id;
    logic [15:0] m_timer;

    initial begin
        m_pend = '0; m_mask = '1; m_tpend = 1'b0; m_phase = 0; m_id = '0; m_timer = '0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_pend = '0; m_mask = '1; m_tpend = 1'b0; m_phase = 0; m_id = '0; m_timer = '0;
            end else begin
                acc = irq_ack && (m_phase == 1);
                act = (m_pend | {31'b0, m_tpend}) & ~m_mask;
                // latched bits keep old value, all unmasked bits OR in the new sample
                nx_pend = (irq_in | (m_pend & LAT)) & ~MSK;
                if (acc) nx_pend[m_id] = irq_in[m_id] & ~MSK[m_id];
                tevt = 1'b0;
`ifdef PICORV_IRQ_TIMER_EN
                tevt = !timer_wr && (m_timer == 16'd1) && !MSK[0];
                if (timer_wr) m_timer = timer_wdata;
                else if (m_timer > 0) m_timer = m_timer - 16'd1;
`endif
                m_tpend = tevt || (m_tpend && !(acc && m_id == 5'd0));
                if (mask_wr) m_mask = mask_wdata | MSK;
                case (m_phase)
                    0: if (act != 0) begin
                        m_phase = 1;
                        low = act & (~act + 32'd1);   // isolate lowest set bit
                        m_id = '0;
                        while (low > 32'd1) begin
                            low = low >> 1;
                            m_id = m_id + 5'd1;
                        end
                    end
                    1: if (irq_ack) m_phase = 2;
                    default: m_phase = 0;
                endcase
                m_pend = nx_pend;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_req",   32'(irq_req),     32'(m_phase == 1));
                check("m_id",    32'(irq_id),      (m_phase == 1) ? 32'(m_id) : 32'd0);
                check("m_pend",  irq_pending,      m_pend | {31'b0, m_tpend});
                check("m_mask",  irq_mask,         m_mask);
                check("m_timer", 32'(timer_q),     32'(m_timer));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #1 resetn = 1'b0;
        #1;
        check("rst_req",   32'(irq_req), 32'd0);
        check("rst_id",    32'(irq_id), 32'd0);
        check("rst_pend",  irq_pending, 32'd0);
        check("rst_mask",  irq_mask, 32'hffff_ffff);
        check("rst_timer", 32'(timer_q), 32'd0);
        chk_en = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(1);

        // unmask everything; channel 2 stays masked
        mask_wr = 1'b1; mask_wdata = 32'h0;
        tick(1);
        mask_wr = 1'b0;
        check("mask_wr", irq_mask, 32'h0000_0004);

        // single pulse on channel 5
        irq_in = 32'h20; tick(1); irq_in = '0;
        check("p5_pend", 32'(irq_pending[5]), 32'd1);
        check("p5_noreq", 32'(irq_req), 32'd0);
        tick(1);
        check("p5_req", 32'(irq_req), 32'd1);
        check("p5_id", 32'(irq_id), 32'd5);
        tick(2);
        check("p5_hold", 32'(irq_id), 32'd5);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("p5_gap", 32'(irq_req), 32'd0);
        check("p5_clr", 32'(irq_pending[5]), 32'd0);
        tick(1);

        // channels 3 and 9 together: 3 first, then 9 after the gap
        irq_in = 32'h208; tick(1); irq_in = '0;
        tick(1);
        check("pr_id3", 32'(irq_id), 32'd3);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("pr_gap", 32'(irq_req), 32'd0);
        tick(1);
        check("pr_idle", 32'(irq_req), 32'd0);
        tick(1);
        check("pr_req9", 32'(irq_req), 32'd1);
        check("pr_id9", 32'(irq_id), 32'd9);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        tick(2);

        // permanently masked channel 2
        irq_in = 32'h4; tick(1); irq_in = '0;
        check("m2_pend", 32'(irq_pending[2]), 32'd0);
        check("m2_mask", 32'(irq_mask[2]), 32'd1);
        tick(2);
        check("m2_noreq", 32'(irq_req), 32'd0);

        // level channel 7 held three cycles
        irq_in = 32'h80; tick(1);
        check("l7_pend", 32'(irq_pending[7]), 32'd1);
        tick(1);
        check("l7_id", 32'(irq_id), 32'd7);
        tick(1);
        irq_in = '0;
        check("l7_still", 32'(irq_pending[7]), 32'd1);
        tick(1);
        check("l7_drop", 32'(irq_pending[7]), 32'd0);
        check("l7_frozen", 32'(irq_id), 32'd7);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        tick(3);
        check("l7_noreq", 32'(irq_req), 32'd0);

        // frozen id while a lower channel arrives; mask write with acceptance
        irq_in = 32'h40; tick(1); irq_in = '0;
        tick(1);
        check("fz_id6", 32'(irq_id), 32'd6);
        irq_in = 32'h2; tick(1); irq_in = '0;
        check("fz_keep6", 32'(irq_id), 32'd6);
        check("fz_pend1", 32'(irq_pending[1]), 32'd1);
        mask_wr = 1'b1; mask_wdata = 32'h100; irq_ack = 1'b1;
        tick(1);
        mask_wr = 1'b0; irq_ack = 1'b0;
        check("mw_mask", irq_mask, 32'h0000_0104);
        check("mw_clr6", 32'(irq_pending[6]), 32'd0);
        tick(2);
        check("fz_id1", 32'(irq_id), 32'd1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("fz_clr1", 32'(irq_pending[1]), 32'd0);
        tick(1);

        // set beats same-edge acceptance clear on channel 4
        irq_in = 32'h10; tick(1); irq_in = '0;
        tick(1);
        check("sw_id4", 32'(irq_id), 32'd4);
        irq_ack = 1'b1; irq_in = 32'h10; tick(1); irq_ack = 1'b0; irq_in = '0;
        check("sw_pend4", 32'(irq_pending[4]), 32'd1);
        tick(2);
        check("sw_again", 32'(irq_id), 32'd4);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("sw_clr4", 32'(irq_pending[4]), 32'd0);
        tick(1);

        // ack while idle is ignored (channel 0 pending but masked)
        mask_wr = 1'b1; mask_wdata = 32'h1; tick(1); mask_wr = 1'b0;
        irq_in = 32'h1; tick(1); irq_in = '0;
        irq_ack = 1'b1; tick(2); irq_ack = 1'b0;
        check("ia_pend0", 32'(irq_pending[0]), 32'd1);
        check("ia_noreq", 32'(irq_req), 32'd0);
        mask_wr = 1'b1; mask_wdata = 32'h0; tick(1); mask_wr = 1'b0;
        tick(1);
        check("ia_req0", 32'(irq_req), 32'd1);
        check("ia_id0", 32'(irq_id), 32'd0);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("ia_clr0", 32'(irq_pending[0]), 32'd0);
        tick(1);

`ifdef PICORV_IRQ_TIMER_EN
        timer_wr = 1'b1; timer_wdata = 16'd3; tick(1); timer_wr = 1'b0;
        check("t_3", 32'(timer_q), 32'd3);
        tick(1); check("t_2", 32'(timer_q), 32'd2);
        tick(1); check("t_1", 32'(timer_q), 32'd1);
        tick(1); check("t_0", 32'(timer_q), 32'd0);
        check("t_evt", 32'(irq_pending[0]), 32'd1);
        tick(1);
        check("t_id0", 32'(irq_id), 32'd0);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        tick(1);
        timer_wr = 1'b1; timer_wdata = 16'd2; tick(1); timer_wr = 1'b0;
        tick(1);
        check("t_pre", 32'(timer_q), 32'd1);
        timer_wr = 1'b1; timer_wdata = 16'd5; tick(1); timer_wr = 1'b0;
        check("t_reload", 32'(timer_q), 32'd5);
        check("t_noevt", 32'(irq_pending[0]), 32'd0);
        timer_wr = 1'b1; timer_wdata = 16'd0; tick(1); timer_wr = 1'b0;
        tick(3);
        check("t_stop", 32'(timer_q), 32'd0);
        check("t_silent", 32'(irq_pending[0]), 32'd0);
`else
        timer_wr = 1'b1; timer_wdata = 16'd3; tick(1); timer_wr = 1'b0;
        check("nt_q", 32'(timer_q), 32'd0);
        tick(4);
        check("nt_q2", 32'(timer_q), 32'd0);
        check("nt_pend0", 32'(irq_pending[0]), 32'd0);
`endif

        // reset in the middle of a request
        irq_in = 32'h400; tick(1); irq_in = '0;
        tick(1);
        check("rr_id10", 32'(irq_id), 32'd10);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rr_req", 32'(irq_req), 32'd0);
        check("rr_id", 32'(irq_id), 32'd0);
        check("rr_pend", irq_pending, 32'd0);
        check("rr_timer", 32'(timer_q), 32'd0);
        check("rr_mask", irq_mask, 32'hffff_ffff);
        tick(2);
        resetn = 1'b1;
        mask_wr = 1'b1; mask_wdata = 32'h0; irq_in = 32'h800;
        tick(1);
        mask_wr = 1'b0; irq_in = '0;
        check("rr_wait", 32'(irq_req), 32'd0);
        tick(1);
        check("rr_first", 32'(irq_id), 32'd11);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
